button_conditioner: RTL

Input-side counterpart to the board heartbeat path. Conditions one raw, asynchronous, bouncing pushbutton into clean signals in the clk domain:
- a synchronized, debounced level
- single-cycle press and release pulses
- a stretched, glitch-free active-high system reset for CPU_top and the heartbeat logic

Sits between the board pin and all board-level reset and control consumers.

---
 rtl/button_conditioner.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: raw pushbutton -> synced/debounced level, press/release pulses, stretched sys_reset.
// Rev 1.0. Optional long-press pulse built only when BTN_LONG_PRESS_EN is defined.
`default_nettype none

module button_conditioner #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int CNT_W           = 21,
  parameter int STRETCH_CYCLES  = 16,
  parameter int LONG_CYCLES     = 250000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic sys_reset,
  output logic btn_long
);

  localparam logic RELEASED_LVL = (ACTIVE_LOW != 0);
  localparam int   SCNT_W       = $clog2(STRETCH_CYCLES + 1);

  localparam logic [1:0] S_RELEASED     = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  if (DEBOUNCE_CYCLES < 1 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
      STRETCH_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
    $error("button_conditioner: illegal parameter combination");
  end

  logic             sync1, sync2, p;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cnt_done;
  logic             level_nxt, press_nxt, release_nxt;
  logic [SCNT_W-1:0] scnt;

  // Sync flops restart at the released pin level so a held button is re-qualified after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= RELEASED_LVL;
      sync2 <= RELEASED_LVL;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign p        = sync2 ^ RELEASED_LVL;
  assign cnt_done = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RELEASED;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_RELEASED: begin
        if (p) begin
          state_nxt = S_PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!p) begin
          state_nxt = S_RELEASED;
          cnt_nxt   = '0;
        end else if (cnt_done) begin
          state_nxt = S_PRESSED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_PRESSED: begin
        if (!p) begin
          state_nxt = S_RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (p) begin
          state_nxt = S_PRESSED;
          cnt_nxt   = '0;
        end else if (cnt_done) begin
          state_nxt = S_RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    press_nxt   = (state == S_PRESS_WAIT) && p && cnt_done;
    release_nxt = (state == S_RELEASE_WAIT) && !p && cnt_done;
    level_nxt   = btn_level;
    if (press_nxt)
      level_nxt = 1'b1;
    else if (release_nxt)
      level_nxt = 1'b0;
  end

  // sys_reset is registered so that it always equals (scnt != 0) without a decode glitch.
  always_ff @(posedge clk) begin
    if (reset || btn_level) begin
      scnt      <= SCNT_W'(STRETCH_CYCLES);
      sys_reset <= 1'b1;
    end else if (scnt != '0) begin
      scnt      <= scnt - 1'b1;
      sys_reset <= (scnt != SCNT_W'(1));
    end else begin
      sys_reset <= 1'b0;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);

  logic [LONG_W-1:0] lcnt;
  logic              long_q;

  // Parking at LONG_CYCLES limits btn_long to one pulse per press.
  always_ff @(posedge clk) begin
    if (reset) begin
      lcnt   <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_nxt) begin
        lcnt <= '0;
      end else if (state == S_PRESSED) begin
        if (lcnt == LONG_W'(LONG_CYCLES - 1)) begin
          long_q <= 1'b1;
          lcnt   <= LONG_W'(LONG_CYCLES);
        end else if (lcnt != LONG_W'(LONG_CYCLES)) begin
          lcnt <= lcnt + 1'b1;
        end
      end
    end
  end

  assign btn_long = long_q;
`else
  assign btn_long = 1'b0;
`endif

endmodule

`default_nettype wire
